ldpc_frame_assembler: RTL and testbench

LDPC_FRAME_ASSEMBLER -- requirements
Module: ldpc_frame_assembler

---
 rtl/ldpc_frame_assembler.sv | 215 +++++++++++++++++++++
 tb/tb_ldpc_frame_assembler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_frame_assembler.sv
// ldpc_frame_assembler
// Builds one DVB-style FECFRAME byte stream per frame: the BCH information
// bytes pass straight through with one enabled cycle of latency, followed by
// exactly parity_len parity bytes taken from the LDPC encoder. The parity bytes
// are held in an on-chip buffer because they may arrive before, during or
// after the information bytes.
//
// Ports
//   sys_clk, rst          single clock, asynchronous active-high reset
//   fs_en                 clock enable; nothing advances while low
//   parity_len            parity bytes in this frame (0 encodes 2^PAR_AW),
//                         sampled with the accepted info_sof byte
//   info_vld/sof/eof      information byte strobe and framing
//   info_byte             information byte
//   info_rdy              information bytes are accepted (IDLE/INFO)
//   parity_vld            parity strobe from the LDPC encoder
//   parity_byte           parity byte from the LDPC encoder
//   dout_vld/sof/eof      output byte strobe and framing
//   dout                  output FECFRAME byte
//   frame_done            one-cycle pulse alongside dout_eof
//   err_drop              sticky: some info or parity byte was dropped
module ldpc_frame_assembler #(
  parameter int unsigned PAR_AW = 13
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              fs_en,
  input  logic [PAR_AW-1:0] parity_len,
  input  logic              info_vld,
  input  logic              info_sof,
  input  logic              info_eof,
  input  logic [7:0]        info_byte,
  output logic              info_rdy,
  input  logic              parity_vld,
  input  logic [7:0]        parity_byte,
  output logic              dout_vld,
  output logic              dout_sof,
  output logic              dout_eof,
  output logic [7:0]        dout,
  output logic              frame_done,
  output logic              err_drop
);

  // Counters carry one extra bit so a completely full buffer is representable.
  localparam int unsigned CW    = PAR_AW + 1;
  localparam int unsigned DEPTH = 1 << PAR_AW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFO     = 2'd1,
    PAR_WAIT = 2'd2,
    PAR_OUT  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   plen_q;
  logic [7:0]      par_mem [DEPTH];

  logic            info_take;
  logic            take_sof;
  logic            par_wr;
  logic            par_rd;
  logic            rd_last;
  logic            err_set;
  logic            par_avail;

  assign par_avail = (wr_cnt > rd_cnt);
  assign info_rdy  = (state_q == IDLE) || (state_q == INFO);

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (fs_en) begin
      state_q <= state_d;
    end
  end

  // Next state plus per-cycle accept/write/read/drop decisions.
  always_comb begin
    state_d   = state_q;
    info_take = 1'b0;
    take_sof  = 1'b0;
    par_wr    = 1'b0;
    par_rd    = 1'b0;
    rd_last   = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      IDLE: begin
        // Stray info bytes before a start-of-frame are ignored without error.
        if (info_vld && info_sof) begin
          info_take = 1'b1;
          take_sof  = 1'b1;
          state_d   = info_eof ? PAR_WAIT : INFO;
        end
      end
      INFO: begin
        if (info_vld) begin
          info_take = 1'b1;
          if (info_sof) begin
            err_set = 1'b1;
          end
          if (info_eof) begin
            state_d = PAR_WAIT;
          end
        end
      end
      PAR_WAIT: begin
        if (info_vld) begin
          err_set = 1'b1;
        end
        if (par_avail) begin
          state_d = PAR_OUT;
        end
      end
      PAR_OUT: begin
        if (info_vld) begin
          err_set = 1'b1;
        end
        if (par_avail) begin
          par_rd = 1'b1;
          if (rd_cnt == plen_q - CW'(1)) begin
            rd_last = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Parity is only buffered while a frame is open and the buffer has room.
    if (parity_vld) begin
      if ((state_q == IDLE) || (wr_cnt == plen_q)) begin
        err_set = 1'b1;
      end else begin
        par_wr = 1'b1;
      end
    end
  end

  // Parity buffer write port; no reset so it maps onto a RAM macro.
  always_ff @(posedge sys_clk) begin
    if (fs_en && par_wr) begin
      par_mem[wr_cnt[PAR_AW-1:0]] <= parity_byte;
    end
  end

  // Frame bookkeeping: latched length and buffer pointers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      plen_q <= '0;
    end else if (fs_en) begin
      if (take_sof) begin
        plen_q <= (parity_len == '0) ? CW'(DEPTH) : {1'b0, parity_len};
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (par_wr) begin
          wr_cnt <= wr_cnt + CW'(1);
        end
        if (par_rd) begin
          rd_cnt <= rd_cnt + CW'(1);
        end
      end
    end
  end

  // Output register; in PAR_OUT it doubles as the buffer's read data register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_vld   <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_done <= 1'b0;
    end else if (fs_en) begin
      if (info_take) begin
        dout       <= info_byte;
        dout_vld   <= 1'b1;
        dout_sof   <= take_sof;
        dout_eof   <= 1'b0;
        frame_done <= 1'b0;
      end else if (par_rd) begin
        dout       <= par_mem[rd_cnt[PAR_AW-1:0]];
        dout_vld   <= 1'b1;
        dout_sof   <= 1'b0;
        dout_eof   <= rd_last;
        frame_done <= rd_last;
      end else begin
        dout_vld   <= 1'b0;
        dout_sof   <= 1'b0;
        dout_eof   <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Sticky drop flag.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      err_drop <= 1'b0;
    end else if (fs_en && err_set) begin
      err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldpc_frame_assembler.sv
// Self-checking bench for ldpc_frame_assembler. A frame is described by its
// info bytes, parity length and parity bytes; the expected output is simply
// the info bytes followed by the first parity_len parity bytes.
module tb_ldpc_frame_assembler;

  localparam int unsigned PAR_AW = 13;
  localparam int unsigned DEPTH  = 1 << PAR_AW;

  typedef logic [7:0] bq_t [$];

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              fs_en = 1'b1;
  logic [PAR_AW-1:0] parity_len = '0;
  logic              info_vld = 1'b0;
  logic              info_sof = 1'b0;
  logic              info_eof = 1'b0;
  logic [7:0]        info_byte = '0;
  logic              info_rdy;
  logic              parity_vld = 1'b0;
  logic [7:0]        parity_byte = '0;
  logic              dout_vld;
  logic              dout_sof;
  logic              dout_eof;
  logic [7:0]        dout;
  logic              frame_done;
  logic              err_drop;

  ldpc_frame_assembler #(.PAR_AW(PAR_AW)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .fs_en       (fs_en),
    .parity_len  (parity_len),
    .info_vld    (info_vld),
    .info_sof    (info_sof),
    .info_eof    (info_eof),
    .info_byte   (info_byte),
    .info_rdy    (info_rdy),
    .parity_vld  (parity_vld),
    .parity_byte (parity_byte),
    .dout_vld    (dout_vld),
    .dout_sof    (dout_sof),
    .dout_eof    (dout_eof),
    .dout        (dout),
    .frame_done  (frame_done),
    .err_drop    (err_drop)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Bench-side state shared with the monitor (written only by the main block).
  bit          toggle = 1'b0;
  bit          exp_err = 1'b0;
  int          out_base = 0;
  int          n_info_cur = 0;
  int          par_in = 0;
  int          plen_cur = 0;

  // Monitor state (written only by the monitor).
  logic [7:0]  out_byte [$];
  bit          out_sof [$];
  bit          out_eof [$];
  bit          out_done [$];
  int          done_total = 0;
  int          hold_viol = 0;
  int          cause_viol = 0;
  bit          en_last = 1'b0;
  bit          snap_ok = 1'b0;
  logic [11:0] snap = '0;

  always @(posedge sys_clk) en_last <= fs_en;

  // Capture one output byte per enabled cycle; check outputs hold when
  // disabled and that parity never leaves before it was delivered.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (en_last && dout_vld) begin
        out_byte.push_back(dout);
        out_sof.push_back(dout_sof);
        out_eof.push_back(dout_eof);
        out_done.push_back(frame_done);
        if (frame_done) done_total++;
        if (out_byte.size() - out_base > n_info_cur + par_in) cause_viol++;
      end
      if (!en_last && snap_ok &&
          ({dout_vld, dout_sof, dout_eof, frame_done, dout} !== snap)) hold_viol++;
      snap    = {dout_vld, dout_sof, dout_eof, frame_done, dout};
      snap_ok = 1'b1;
    end else begin
      snap_ok = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One enabled clock; in toggle mode it is preceded by a disabled clock.
  task automatic cyc();
    if (toggle) begin
      fs_en = 1'b0;
      @(posedge sys_clk);
      #1;
    end
    fs_en = 1'b1;
    @(posedge sys_clk);
    if (parity_vld && par_in < plen_cur) par_in++;
    #1;
  endtask

  function automatic bq_t seq(input int start, input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'(start + k));
    return q;
  endfunction

  function automatic bq_t rnd(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic begin_frame(input int n_info, input int plen);
    out_base   = out_byte.size();
    n_info_cur = n_info;
    par_in     = 0;
    plen_cur   = plen;
  endtask

  // Compare the captured stream since out_base with the expected stream.
  task automatic compare_stream(input string tag, input bq_t exp_q);
    int n;
    int mism;
    int sof_bad;
    int eof_bad;
    int last;
    n       = out_byte.size() - out_base;
    mism    = 0;
    sof_bad = 0;
    eof_bad = 0;
    last    = exp_q.size() - 1;
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int k = 0; k < n && k < exp_q.size(); k++) begin
      if (out_byte[out_base + k] !== exp_q[k]) mism++;
      if (out_sof[out_base + k] != (k == 0)) sof_bad++;
      if (out_eof[out_base + k] != (k == last) || out_done[out_base + k] != (k == last)) eof_bad++;
    end
    check({tag, "_data"}, 32'(mism), 32'd0);
    check({tag, "_sof"}, 32'(sof_bad), 32'd0);
    check({tag, "_eof"}, 32'(eof_bad), 32'd0);
  endtask

  // Drive one frame and check it. inj_beat: parity beat index on which a
  // stray info byte is injected (-1 for none).
  task automatic run_frame(input string tag, input bq_t info_q, input int plen,
                           input bq_t par_q, input bit ilv, input int gap,
                           input int extra, input int inj_beat, input bit set_err);
    int   pi;
    int   base;
    int   waited;
    bq_t  exp_q;
    pi = 0;
    begin_frame(info_q.size(), plen);
    base       = done_total;
    parity_len = PAR_AW'(plen);
    foreach (info_q[i]) begin
      info_vld  = 1'b1;
      info_sof  = (i == 0);
      info_eof  = (i == info_q.size() - 1);
      info_byte = info_q[i];
      if (ilv && i > 0 && pi < plen) begin
        parity_vld  = 1'b1;
        parity_byte = par_q[pi];
        pi++;
      end else begin
        parity_vld = 1'b0;
      end
      cyc();
    end
    info_vld   = 1'b0;
    info_sof   = 1'b0;
    info_eof   = 1'b0;
    parity_vld = 1'b0;
    check({tag, "_rdy_par"}, 32'(info_rdy), 32'd0);
    while (pi < plen) begin
      parity_vld  = 1'b1;
      parity_byte = par_q[pi];
      if (pi == inj_beat) begin
        info_vld  = 1'b1;
        info_byte = 8'($urandom);
      end
      cyc();
      pi++;
      parity_vld = 1'b0;
      info_vld   = 1'b0;
      if (pi == 1 && gap > 0) repeat (gap) cyc();
    end
    repeat (extra) begin
      parity_vld  = 1'b1;
      parity_byte = 8'($urandom);
      cyc();
      parity_vld = 1'b0;
    end
    waited = 0;
    while (done_total == base && waited < plen + 64) begin
      cyc();
      waited++;
    end
    check({tag, "_done"}, 32'(done_total - base), 32'd1);
    check({tag, "_rdy_idle"}, 32'(info_rdy), 32'd1);
    exp_q = info_q;
    for (int k = 0; k < plen; k++) exp_q.push_back(par_q[k]);
    compare_stream(tag, exp_q);
    exp_err = exp_err | set_err;
    check({tag, "_err"}, 32'(err_drop), 32'(exp_err));
    check({tag, "_hold"}, 32'(hold_viol), 32'd0);
    check({tag, "_causal"}, 32'(cause_viol), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t a;
    bq_t b;
    int  n;
    int  eofs;
    int  plen;

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #3;
    check("rst_vld", 32'(dout_vld), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_eof", 32'(dout_eof), 32'd0);
    check("rst_err", 32'(err_drop), 32'd0);
    check("rst_rdy", 32'(info_rdy), 32'd1);
    rst = 1'b0;
    @(posedge sys_clk);
    #1;
    cyc();

    // Stray info byte in IDLE is discarded silently.
    begin_frame(0, 0);
    info_vld  = 1'b1;
    info_byte = 8'h55;
    cyc();
    info_vld = 1'b0;
    cyc();
    check("idle_stray_out", 32'(out_byte.size() - out_base), 32'd0);
    check("idle_stray_err", 32'(err_drop), 32'd0);

    // Frame 1: parity after info.
    run_frame("f1", seq(8'h10, 6), 4, seq(8'hA0, 4), 1'b0, 0, 0, -1, 1'b0);
    // Frame 2: parity interleaved with info.
    run_frame("f2", seq(8'h10, 6), 4, seq(8'hA0, 4), 1'b1, 0, 0, -1, 1'b0);
    // Frame 3: parity starvation gap after the first parity byte.
    run_frame("f3", rnd(5), 3, rnd(3), 1'b0, 5, 0, -1, 1'b0);
    // Frame 4: info during parity output and one surplus parity byte.
    run_frame("f4", rnd(4), 4, rnd(4), 1'b0, 0, 1, 2, 1'b1);
    // Frame 5: clock enable toggled every cycle; drop flag still sticky.
    toggle = 1'b1;
    run_frame("f5", seq(8'h10, 6), 4, seq(8'hA0, 4), 1'b0, 0, 0, -1, 1'b0);
    toggle = 1'b0;

    // Frame 6: reset after the third info byte aborts the frame.
    a = rnd(3);
    begin_frame(8, 4);
    parity_len = PAR_AW'(4);
    foreach (a[i]) begin
      info_vld  = 1'b1;
      info_sof  = (i == 0);
      info_eof  = 1'b0;
      info_byte = a[i];
      cyc();
    end
    info_vld = 1'b0;
    info_sof = 1'b0;
    #6;
    rst = 1'b1;
    #1;
    rst     = 1'b0;
    exp_err = 1'b0;
    check("f6_rst_vld", 32'(dout_vld), 32'd0);
    check("f6_rst_err", 32'(err_drop), 32'd0);
    check("f6_rst_rdy", 32'(info_rdy), 32'd1);
    n    = out_byte.size() - out_base;
    eofs = 0;
    for (int k = 0; k < n; k++) if (out_eof[out_base + k]) eofs++;
    check("f6_abort_len", 32'(n), 32'd3);
    check("f6_abort_eof", 32'(eofs), 32'd0);
    cyc();
    run_frame("f6", rnd(7), 5, rnd(5), 1'b1, 0, 0, -1, 1'b0);

    // Random frames; the first is a single sof+eof byte.
    for (int f = 0; f < 6; f++) begin
      n    = (f == 0) ? 1 : int'($urandom_range(1, 8));
      plen = int'($urandom_range(1, 12));
      a    = rnd(n);
      b    = rnd(plen);
      run_frame($sformatf("r%0d", f), a, plen, b, 1'($urandom), int'($urandom_range(0, 3)),
                0, -1, 1'b0);
    end

    // Full-depth frame: parity_len encoded as 0.
    run_frame("full", rnd(2), DEPTH, rnd(DEPTH), 1'b0, 0, 0, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
